itch_msg_fifo: RTL and testbench
================================

# itch_msg_fifo

Buffers canonical parsed ITCH messages from the parser output and presents them to the downstream order-book stage over a valid/ready handshake. The parser has no backpressure input, so this block absorbs bursts, drops messages on overflow, and counts the drops. It sits directly downstream of the parser's canonical output interface.

## Interface

Parameters:
- DEPTH, 16, number of message entries; power of two, at least 4.
- AFULL_THRESH, 14, `almost_full` asserts when `level >= AFULL_THRESH`; must be below or equal to DEPTH.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- in_valid  input  1  parser `parsed_valid`.
- in_type  input  4  parser `parsed_type`.
- in_order_ref  input  64  parser `order_ref`.
- in_side  input  1  parser `side`.
- in_shares  input  32  parser `shares`.
- in_price  input  32  parser `price`.
- in_new_order_ref  input  64  parser `new_order_ref`.
- in_timestamp  input  48  parser `timestamp`.
- in_misc_data  input  64  parser `misc_data`.
- out_valid  output  1  head entry available.
- out_ready  input  1  downstream accepts the head entry.
- out_type, out_order_ref, out_side, out_shares, out_price, out_new_order_ref, out_timestamp, out_misc_data  output  4/64/1/32/32/64/48/64  head entry fields.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  `level >= AFULL_THRESH`.
- overflow  output  1  sticky; set by the first dropped message.
- drop_count  output  16  saturating count of dropped messages.
- max_level  output  $clog2(DEPTH)+1  high-water mark of `level`.

## Operation

- Each entry is a packed record of 309 bits: type, order_ref, side, shares, price, new_order_ref, timestamp, misc_data.
- The storage is a circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus an occupancy counter `level`.
- Push: `in_valid=1` and (`level<DEPTH` or pop this cycle). The record is written at `wr_ptr` and `wr_ptr` increments.
- Drop: `in_valid=1`, `level==DEPTH`, and no pop this cycle. The record is discarded, `overflow` is set to 1, and `drop_count` increments, saturating at 16'hFFFF.
- Pop: `out_valid & out_ready`. `rd_ptr` increments.
- Level update:
  - Push only: +1.
  - Pop only: −1.
  - Both, or neither: unchanged.
- Full with simultaneous pop and push: the push is accepted, it is not counted as a drop, and `level` stays at DEPTH.
- Empty: `out_ready` is ignored and no pop occurs.
- Head presentation is show-ahead: `out_*` fields are read from `rd_ptr`. All `out_*` data fields are forced to 0 while `out_valid=0`.
- `out_valid = (level != 0)`.
- `max_level` updates to the next-cycle `level` whenever that value exceeds the current `max_level`.
- `overflow`, `drop_count` and `max_level` clear only on reset.
- There is no write-through bypass. An entry pushed into an empty FIFO appears on the following cycle.
- `in_type` is not interpreted; every valid input is treated identically.

## Timing

- Reset values (`rst=0` at an edge):
  - `wr_ptr=rd_ptr=level=0`.
  - `out_valid=0` and all `out_*` data fields 0.
  - `almost_full=0`, `overflow=0`, `drop_count=0`, `max_level=0`.
  - Storage contents are not reset.
- Reset mid-operation: all buffered entries are lost. An `in_valid` present in the reset cycle is ignored.
- Latency: a push at edge N gives `out_valid=1` with that entry on the head from edge N onward, i.e. visible in cycle N+1.
- Pop timing: a pop at edge N exposes the next entry (or `out_valid=0`) in the following cycle.
- Sustained throughput: one push and one pop per cycle.
- `level`, `almost_full` and `out_valid` are derived from registered state only; there is no combinational path from `in_valid` to any output.
- `out_ready` has no combinational path to any output.
- The downstream stage may hold `out_ready=0` indefinitely. The head entry then remains stable.

## Configuration

- Macro: `ITCH_FIFO_STATS_EN`.
- Defined: `overflow`, `drop_count` and `max_level` behave as described above.
- Undefined:
  - These three outputs are tied to constant 0 and their registers are not synthesized.
  - Drop behaviour is unchanged: messages are still discarded when full.

## Test plan

- Reset then single push: `in_valid=1`, `in_order_ref=64'h1234`, `in_type=4'd1` for one cycle with `out_ready=1`.
  - Next cycle: `out_valid=1`, `out_order_ref=64'h1234`, `out_type=1`, `level=1`.
  - Cycle after: `out_valid=0`, all `out_*` fields 0.
- Fill with DEPTH=16, `out_ready=0`: push 18 messages with `order_ref` 0..17.
  - Result: `level=16`, `almost_full=1`, `drop_count=2`, `overflow=1`, `max_level=16`.
  - Draining yields refs 0..15 in order.
- Full with simultaneous push and pop: `level=16`, `out_ready=1`, push ref 99.
  - Result: `level` stays 16, `drop_count` unchanged, and ref 99 is the last entry out.
- Wrap-around: 40 cycles of push with `out_ready=1` continuously.
  - Every ref emerges exactly one cycle after its push, in order.
  - `level` never exceeds 1; `max_level=1`.
- Backpressure stability: 3 entries buffered, then `out_ready` toggles 0/1 every cycle.
  - Head fields hold constant while `out_ready=0`.
  - Entries emerge in order on cycles where `out_ready=1`.
- Reset mid-burst: `level=7`, `drop_count=3`, then `rst=0` for one cycle.
  - Next cycle: `level=0`, `out_valid=0`, `drop_count=0`, `overflow=0`, `max_level=0`.
  - With `ITCH_FIFO_STATS_EN` undefined, the stats outputs read 0 throughout the fill test.

Source files
------------

// File: rtl/itch_msg_fifo.sv
// itch_msg_fifo: show-ahead buffer for parsed ITCH messages with drop-on-overflow.
// Statistics outputs (overflow, drop_count, max_level) exist only when ITCH_FIFO_STATS_EN is defined.
module itch_msg_fifo #(
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [3:0]                 in_type,
    input  logic [63:0]                in_order_ref,
    input  logic                       in_side,
    input  logic [31:0]                in_shares,
    input  logic [31:0]                in_price,
    input  logic [63:0]                in_new_order_ref,
    input  logic [47:0]                in_timestamp,
    input  logic [63:0]                in_misc_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_type,
    output logic [63:0]                out_order_ref,
    output logic                       out_side,
    output logic [31:0]                out_shares,
    output logic [31:0]                out_price,
    output logic [63:0]                out_new_order_ref,
    output logic [47:0]                out_timestamp,
    output logic [63:0]                out_misc_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     max_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 309;

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic [RW-1:0] head;
    logic          full;
    logic          pop;
    logic          push;

    assign full      = level == LW'(DEPTH);
    assign out_valid = level != '0;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign level_nxt = (push && !pop) ? level + 1'b1 :
                       (pop && !push) ? level - 1'b1 : level;
    assign almost_full = level >= LW'(AFULL_THRESH);

    // Storage is never reset; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && push)
            mem[wr_ptr] <= {in_type, in_order_ref, in_side, in_shares, in_price,
                            in_new_order_ref, in_timestamp, in_misc_data};
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
        end
    end

    // Show-ahead head, zeroed whenever nothing is buffered
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_type, out_order_ref, out_side, out_shares, out_price,
            out_new_order_ref, out_timestamp, out_misc_data} = head;

`ifdef ITCH_FIFO_STATS_EN
    logic drop;
    assign drop = in_valid && full && !pop;

    // Sticky overflow, saturating drop counter and high-water mark
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            max_level  <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            end
            if (level_nxt > max_level) max_level <= level_nxt;
        end
    end
`else
    assign overflow   = 1'b0;
    assign drop_count = '0;
    assign max_level  = '0;
`endif
endmodule

// File: tb/tb_itch_msg_fifo.sv
// tb_itch_msg_fifo: directed + random stimulus against a queue-based message model.
module tb_itch_msg_fifo;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_type = '0;
    logic [63:0] in_order_ref = '0;
    logic        in_side = 1'b0;
    logic [31:0] in_shares = '0;
    logic [31:0] in_price = '0;
    logic [63:0] in_new_order_ref = '0;
    logic [47:0] in_timestamp = '0;
    logic [63:0] in_misc_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_type;
    logic [63:0] out_order_ref;
    logic        out_side;
    logic [31:0] out_shares;
    logic [31:0] out_price;
    logic [63:0] out_new_order_ref;
    logic [47:0] out_timestamp;
    logic [63:0] out_misc_data;
    logic [LW-1:0] level;
    logic        almost_full;
    logic        overflow;
    logic [15:0] drop_count;
    logic [LW-1:0] max_level;

    itch_msg_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_type(in_type), .in_order_ref(in_order_ref),
        .in_side(in_side), .in_shares(in_shares), .in_price(in_price),
        .in_new_order_ref(in_new_order_ref), .in_timestamp(in_timestamp),
        .in_misc_data(in_misc_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_order_ref(out_order_ref), .out_side(out_side),
        .out_shares(out_shares), .out_price(out_price),
        .out_new_order_ref(out_new_order_ref), .out_timestamp(out_timestamp),
        .out_misc_data(out_misc_data),
        .level(level), .almost_full(almost_full), .overflow(overflow),
        .drop_count(drop_count), .max_level(max_level)
    );

    always #5 clk = ~clk;

    typedef logic [308:0] rec_t;
    rec_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_drops = 0;
    bit   m_ovf = 0;
    int   m_max = 0;

    task automatic chk(input string tag, input logic [308:0] obs, input logic [308:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        rec_t obs_rec;
        rec_t exp_rec;
        obs_rec = {out_type, out_order_ref, out_side, out_shares, out_price,
                   out_new_order_ref, out_timestamp, out_misc_data};
        exp_rec = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", 309'(out_valid), 309'(q.size() != 0));
        chk("head", obs_rec, exp_rec);
        chk("level", 309'(level), 309'(q.size()));
        chk("almost_full", 309'(almost_full), 309'(q.size() >= AF));
`ifdef ITCH_FIFO_STATS_EN
        chk("overflow", 309'(overflow), 309'(m_ovf));
        chk("drop_count", 309'(drop_count), 309'(m_drops));
        chk("max_level", 309'(max_level), 309'(m_max));
`else
        chk("overflow", 309'(overflow), 309'(0));
        chk("drop_count", 309'(drop_count), 309'(0));
        chk("max_level", 309'(max_level), 309'(0));
`endif
    endtask

    task automatic step(input bit v, input bit r, input bit fix = 1'b0,
                        input logic [63:0] ref_v = '0, input logic [3:0] typ = '0);
        rec_t rec;
        bit   pop;
        bit   full;
        in_valid         = v;
        out_ready        = r;
        in_type          = fix ? typ : 4'($urandom);
        in_order_ref     = fix ? ref_v : {$urandom, $urandom};
        in_side          = 1'($urandom);
        in_shares        = $urandom;
        in_price         = $urandom;
        in_new_order_ref = {$urandom, $urandom};
        in_timestamp     = {16'($urandom), $urandom};
        in_misc_data     = {$urandom, $urandom};
        rec = {in_type, in_order_ref, in_side, in_shares, in_price,
               in_new_order_ref, in_timestamp, in_misc_data};
        pop  = (q.size() != 0) && r;
        full = q.size() == DEPTH;
        if (pop) void'(q.pop_front());
        if (v && (!full || pop)) q.push_back(rec);
        else if (v) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
        end
        if (q.size() > m_max) m_max = q.size();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_drops = 0;
        m_ovf   = 0;
        m_max   = 0;
        check_all();
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        do_reset();

        // Single push then empty
        step(1, 1, 1, 64'h1234, 4'd1);
        chk("single_ref", 309'(out_order_ref), 309'(64'h1234));
        chk("single_type", 309'(out_type), 309'(4'd1));
        step(0, 1);

        // Fill past capacity, then drain in order
        do_reset();
        for (int i = 0; i < 18; i++) step(1, 0, 1, 64'(i));
        chk("fill_level", 309'(level), 309'(DEPTH));
        for (int i = 0; i < 16; i++) begin
            chk("drain_ref", 309'(out_order_ref), 309'(i));
            step(0, 1);
        end

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1, 0, 1, 64'(100 + i));
        step(1, 1, 1, 64'd99);
        chk("full_pp_level", 309'(level), 309'(DEPTH));
        for (int i = 0; i < 15; i++) step(0, 1);
        chk("last_ref_99", 309'(out_order_ref), 309'(64'd99));
        step(0, 1);

        // Wrap-around streaming
        do_reset();
        for (int i = 0; i < 40; i++) step(1, 1, 1, 64'(1000 + i));
        step(0, 1);

        // Backpressure stability
        for (int i = 0; i < 3; i++) step(1, 0);
        for (int i = 0; i < 8; i++) step(0, i[0]);

        // Reset mid-burst
        do_reset();
        for (int i = 0; i < 19; i++) step(1, 0);
        for (int i = 0; i < 9; i++) step(0, 1);
        chk("midburst_level", 309'(level), 309'(7));
        do_reset();
        chk("post_reset_level", 309'(level), 309'(0));

        // Random traffic with bias toward filling, then toward draining
        for (int i = 0; i < 300; i++) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
